// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serializes a WIDTH-bit pattern MSB first onto Dout after a valid/ready
// handshake, counts the 1 bits sent and pulses Done for one cycle at the end
// of each transfer.
// Optional feature: define SEQ_PATTERN_TX_PARITY_EN to append one even-parity
// bit (XOR of the captured pattern) after the last data bit.
// All outputs are registered. Each register is loaded with the value its
// output must carry in the state being entered.
module seq_pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Load_valid,
    input  logic [WIDTH-1:0]               Pattern,
    output logic                           Load_ready,
    output logic                           Dout,
    output logic                           Busy,
    output logic                           Done,
    output logic [$clog2(WIDTH+1)-1:0]     Ones_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2
`ifdef SEQ_PATTERN_TX_PARITY_EN
        ,
        ST_PARITY = 2'd3
`endif
    } state_t;

    state_t           state_r;
    // Holds the data bits still to be sent after the one currently on Dout.
    logic [WIDTH-2:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    ones_r;
    logic             dout_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic             parity_r;

    // Even parity over a full pattern word.
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    assign Load_ready = ready_r;
    assign Dout       = dout_r;
    assign Busy       = busy_r;
    assign Done       = done_r;
    assign Ones_count = ones_r;

    // Transfer FSM together with the shift register, bit counter, ones counter and outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            ones_r   <= '0;
            dout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Load_valid && ready_r) begin
                        // The MSB goes straight to Dout so it is visible in the
                        // first cycle after the handshake edge.
                        shift_r  <= Pattern[WIDTH-2:0];
                        dout_r   <= Pattern[WIDTH-1];
                        cnt_r    <= CNT_FULL;
                        ones_r   <= '0;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        ready_r  <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        parity_r <= even_parity(Pattern);
`endif
                        state_r  <= ST_SHIFT;
                    end else begin
                        dout_r   <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                        ready_r  <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    shift_r <= shift_r << 1;
                    cnt_r   <= cnt_r - CNT_ONE;
                    ones_r  <= ones_r + {{(CW-1){1'b0}}, dout_r};
                    if (cnt_r == CNT_ONE) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        dout_r  <= parity_r;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_PARITY;
`else
                        dout_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
`endif
                    end else begin
                        dout_r  <= shift_r[WIDTH-2];
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                    ready_r <= 1'b0;
                end

`ifdef SEQ_PATTERN_TX_PARITY_EN
                ST_PARITY: begin
                    dout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    ready_r <= 1'b0;
                    state_r <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    // Ones_count keeps its final value until the next handshake.
                    dout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end

                default: begin
                    shift_r <= '0;
                    cnt_r   <= '0;
                    dout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
